// File: rtl/if_id_queue.sv
// Two-entry instruction queue between fetch and decode, replacing a bare IF/ID latch.
// When empty it presents a NOP with valid low, so cache-stall bubbles never reach decode as real work.
module if_id_queue #(
    parameter int          DATA_W   = 16,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] inst_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              fetch_stall,
    input  logic              decode_stall,
    input  logic              flush,
    output logic [DATA_W-1:0] inst_out,
    output logic [DATA_W-1:0] pc_out,
    output logic              valid_out,
    output logic              fetch_hold,
    output logic              err
);

    // The state encoding is the entry count; ILLEGAL (3) can only come from an upset.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        ONE     = 2'd1,
        FULL    = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_head;
    logic              r_tail;
    logic              w_head_nxt;
    logic              w_tail_nxt;
    logic [DATA_W-1:0] r_inst [2];
    logic [DATA_W-1:0] r_pc   [2];

    logic w_valid;
    logic w_pop;
    logic w_push;

    always_comb begin
        w_valid = (r_state == ONE) || (r_state == FULL);
        w_pop   = w_valid & ~decode_stall;
        w_push  = ~fetch_stall & ~flush &
                  ((r_state == EMPTY) || (r_state == ONE) || w_pop);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        if (flush || (r_state == ILLEGAL)) begin
            w_state_nxt = EMPTY;
            w_head_nxt  = 1'b0;
            w_tail_nxt  = 1'b0;
        end else begin
            if (w_push) w_tail_nxt = ~r_tail;
            if (w_pop)  w_head_nxt = ~r_head;
            unique case (r_state)
                EMPTY: if (w_push) w_state_nxt = ONE;
                ONE: begin
                    if (w_push && !w_pop)      w_state_nxt = FULL;
                    else if (w_pop && !w_push) w_state_nxt = EMPTY;
                end
                FULL: if (w_pop && !w_push) w_state_nxt = ONE;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    // Entry storage carries no reset; only pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst[r_tail] <= inst_in;
            r_pc[r_tail]   <= pc_in;
        end
    end

    always_comb begin
        valid_out  = w_valid;
        inst_out   = w_valid ? r_inst[r_head] : NOP_INST;
        pc_out     = w_valid ? r_pc[r_head]   : '0;
        fetch_hold = (r_state == FULL) & decode_stall;
        err        = (r_state == ILLEGAL);
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table for the listed scenarios, then random
// traffic compared against a queue-based reference model.
module tb_if_id_queue;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk;
    logic        rst;
    logic [15:0] inst_in;
    logic [15:0] pc_in;
    logic        fetch_stall;
    logic        decode_stall;
    logic        flush;
    logic [15:0] inst_out;
    logic [15:0] pc_out;
    logic        valid_out;
    logic        fetch_hold;
    logic        err;

    int checks   = 0;
    int failures = 0;

    if_id_queue dut (
        .clk          (clk),
        .rst          (rst),
        .inst_in      (inst_in),
        .pc_in        (pc_in),
        .fetch_stall  (fetch_stall),
        .decode_stall (decode_stall),
        .flush        (flush),
        .inst_out     (inst_out),
        .pc_out       (pc_out),
        .valid_out    (valid_out),
        .fetch_hold   (fetch_hold),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] pc;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        logic        r;
        logic [15:0] ii;
        logic [15:0] pi;
        logic        fs;
        logic        ds;
        logic        fl;
        logic        ev;
        logic [15:0] ei;
        logic [15:0] ep;
        logic        eh;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [15:0] ii, input logic [15:0] pi,
                                input logic fs, input logic ds, input logic fl,
                                input logic ev, input logic [15:0] ei, input logic [15:0] ep,
                                input logic eh);
        vec_t v;
        v.r = r; v.ii = ii; v.pi = pi; v.fs = fs; v.ds = ds; v.fl = fl;
        v.ev = ev; v.ei = ei; v.ep = ep; v.eh = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [15:0] ii, input logic [15:0] pi,
                         input logic fs, input logic ds, input logic fl);
        rst = r; inst_in = ii; pc_in = pi;
        fetch_stall = fs; decode_stall = ds; flush = fl;
        #1;
    endtask

    // Reference: a FIFO of at most two entries following the push/pop rules.
    task automatic model_update();
        bit pop, push;
        ent_t e;
        if (rst || flush) begin
            mq.delete();
        end else begin
            pop  = (mq.size() > 0) && !decode_stall;
            push = !fetch_stall && ((mq.size() < 2) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.inst = inst_in;
                e.pc   = pc_in;
                mq.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic        ev;
        logic [15:0] ei, ep;
        ev = (mq.size() > 0);
        ei = ev ? mq[0].inst : NOP;
        ep = ev ? mq[0].pc : 16'h0000;
        chk({tag, ".valid"}, {15'd0, valid_out}, {15'd0, ev});
        if (ev) begin
            chk({tag, ".inst"}, inst_out, ei);
            chk({tag, ".pc"}, pc_out, ep);
        end else begin
            chk({tag, ".inst_nop"}, inst_out, ei);
            chk({tag, ".pc_zero"}, pc_out, ep);
        end
        chk({tag, ".hold"}, {15'd0, fetch_hold},
            {15'd0, (mq.size() == 2) && decode_stall});
        chk({tag, ".err"}, {15'd0, err}, 16'd0);
    endtask

    initial begin
        // Reset stream
        tbl.push_back(mk(0,16'h1111,16'h0002,0,0,0, 0,NOP,16'h0000,0));
        tbl.push_back(mk(0,16'h2222,16'h0004,0,0,0, 1,16'h1111,16'h0002,0));
        tbl.push_back(mk(0,16'h3333,16'h0006,0,0,0, 1,16'h2222,16'h0004,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       1,16'h3333,16'h0006,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       0,NOP,16'h0000,0));
        // Decode stall for 3 cycles with 0x1111 at the head
        tbl.push_back(mk(0,16'h1111,16'h0002,0,0,0, 0,NOP,16'h0000,0));
        tbl.push_back(mk(0,16'h2222,16'h0004,0,1,0, 1,16'h1111,16'h0002,0));
        tbl.push_back(mk(0,16'h3333,16'h0006,0,1,0, 1,16'h1111,16'h0002,1));
        tbl.push_back(mk(0,16'h3333,16'h0006,0,1,0, 1,16'h1111,16'h0002,1));
        tbl.push_back(mk(0,16'h3333,16'h0006,0,0,0, 1,16'h1111,16'h0002,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       1,16'h2222,16'h0004,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       1,16'h3333,16'h0006,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       0,NOP,16'h0000,0));
        // Cache stall: one real instruction drains, then 4 bubble cycles
        tbl.push_back(mk(0,16'h5555,16'h000A,0,0,0, 0,NOP,16'h0000,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       1,16'h5555,16'h000A,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       0,NOP,16'h0000,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       0,NOP,16'h0000,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       0,NOP,16'h0000,0));
        // Flush while full; 0xCCCC must be dropped
        tbl.push_back(mk(0,16'hAAAA,16'h0010,0,1,0, 0,NOP,16'h0000,0));
        tbl.push_back(mk(0,16'hBBBB,16'h0012,0,1,0, 1,16'hAAAA,16'h0010,0));
        tbl.push_back(mk(0,16'hCCCC,16'h0014,0,0,1, 1,16'hAAAA,16'h0010,0));
        tbl.push_back(mk(0,16'hDDDD,16'h0016,0,0,0, 0,NOP,16'h0000,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       1,16'hDDDD,16'h0016,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       0,NOP,16'h0000,0));
        // Simultaneous pop and push while full
        tbl.push_back(mk(0,16'h1000,16'h0020,0,1,0, 0,NOP,16'h0000,0));
        tbl.push_back(mk(0,16'h2000,16'h0022,0,1,0, 1,16'h1000,16'h0020,0));
        tbl.push_back(mk(0,16'h3000,16'h0024,0,0,0, 1,16'h1000,16'h0020,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,1,0,       1,16'h2000,16'h0022,1));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       1,16'h2000,16'h0022,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       1,16'h3000,16'h0024,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       0,NOP,16'h0000,0));
        // Reset while full and stalled
        tbl.push_back(mk(0,16'h7777,16'h0030,0,1,0, 0,NOP,16'h0000,0));
        tbl.push_back(mk(0,16'h8888,16'h0032,0,1,0, 1,16'h7777,16'h0030,0));
        tbl.push_back(mk(1,16'h9999,16'h0034,0,1,0, 1,16'h7777,16'h0030,1));
        tbl.push_back(mk(0,16'h9999,16'h0034,0,0,0, 0,NOP,16'h0000,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       1,16'h9999,16'h0034,0));
        tbl.push_back(mk(0,NOP,16'h0000,1,0,0,       0,NOP,16'h0000,0));

        apply(1, 16'h0000, 16'h0000, 1, 0, 0);
        step();
        step();
        apply(0, 16'h0000, 16'h0000, 1, 0, 0);
        chk("reset.valid", {15'd0, valid_out}, 16'd0);
        chk("reset.inst",  inst_out, NOP);
        chk("reset.pc",    pc_out, 16'h0000);
        chk("reset.hold",  {15'd0, fetch_hold}, 16'd0);
        chk("reset.err",   {15'd0, err}, 16'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].ii, tbl[i].pi, tbl[i].fs, tbl[i].ds, tbl[i].fl);
            chk($sformatf("vec%0d.valid", i), {15'd0, valid_out}, {15'd0, tbl[i].ev});
            chk($sformatf("vec%0d.inst", i), inst_out, tbl[i].ei);
            chk($sformatf("vec%0d.pc", i), pc_out, tbl[i].ep);
            chk($sformatf("vec%0d.hold", i), {15'd0, fetch_hold}, {15'd0, tbl[i].eh});
            chk($sformatf("vec%0d.err", i), {15'd0, err}, 16'd0);
            step();
        end

        apply(1, 16'h0000, 16'h0000, 1, 0, 0);
        step();
        for (int n = 0; n < 3000; n++) begin
            apply(($urandom_range(0, 99) == 0),
                  16'($urandom), 16'($urandom),
                  ($urandom_range(0, 99) < 25),
                  ($urandom_range(0, 99) < 35),
                  ($urandom_range(0, 99) < 8));
            check_model($sformatf("rnd%0d", n));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
